// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC and IF/ID register for the 5-stage MIPS pipeline.
// Picks the next PC, addresses instruction memory and flags fetches that fault.
module fetch_pc_unit #(
  parameter logic [31:0] PC_RESET      = 32'h0000_3000,
  parameter logic [31:0] IM_BASE       = 32'h0000_3000,
  parameter int          IM_WORDS_LOG2 = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [1:0]               npc_sel,
  input  logic                     br_taken,
  input  logic [15:0]              imm16_d,
  input  logic [25:0]              index26_d,
  input  logic [31:0]              rs_val_d,
  input  logic [31:0]              instr_f,
  output logic [IM_WORDS_LOG2-1:0] im_addr,
  output logic [31:0]              pc_f,
  output logic [31:0]              ir_d,
  output logic [31:0]              pc_d,
  output logic [31:0]              pc8_d,
  output logic                     fetch_err_d
);

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_sel_e;

  // One past the last mapped byte; 33 bits so a base near the top of memory cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd4 << IM_WORDS_LOG2);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;
  logic        fault_f;

  // Only the word-index bits of (pc_f - IM_BASE) matter, so subtract just those bits.
  assign im_addr = pc_f[IM_WORDS_LOG2+1:2] - IM_BASE[IM_WORDS_LOG2+1:2];

  assign fault_f = (pc_f[1:0] != 2'b00)
                || (pc_f < IM_BASE)
                || ({1'b0, pc_f} >= IM_END);

  assign pc_plus4  = pc_f + 32'd4;
  assign br_target = pc_d + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
  assign j_target  = {pc_d[31:28], index26_d, 2'b00};
  assign pc8_d     = pc_d + 32'd8;

  // NOTE: npc gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    npc = pc_plus4;
    case (npc_sel_e'(npc_sel))
      NPC_BRANCH: if (br_taken) npc = br_target;
      NPC_JUMP:   npc = j_target;
      NPC_JR:     npc = rs_val_d;
      default:    npc = pc_plus4;
    endcase
  end

  // NOTE: state is written with <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f        <= PC_RESET;
      ir_d        <= 32'h0;
      pc_d        <= 32'h0;
      fetch_err_d <= 1'b0;
    end else if (!stall) begin
      pc_f <= npc;
      pc_d <= pc_f;
      if (fault_f) begin
        ir_d        <= 32'h0;
        fetch_err_d <= 1'b1;
      end else begin
        ir_d        <= instr_f;
        fetch_err_d <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage front end of the 5-stage MIPS pipeline.
- Owns the F-stage program counter and computes the next PC (sequential, branch, jump, jump-register).
- Drives the word address of the instruction memory, which returns the instruction combinationally in the same cycle.
- Captures that instruction into the IF/ID pipeline register for the decode stage; supports stall and fetch-fault marking.

Parameters:
PC_RESET, 32'h00003000, PC value loaded on reset
IM_BASE, 32'h00003000, byte address mapped to instruction-memory word 0
IM_WORDS_LOG2, 10, log2 of instruction-memory depth in words (1024 words)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall; holds PC and IF/ID register
npc_sel  in  2  next-PC select from decode: 00 PC+4, 01 branch, 10 jump (j/jal), 11 jr/jalr
br_taken  in  1  branch condition result from decode; only meaningful when npc_sel=01
imm16_d  in  16  branch offset field of the D-stage instruction
index26_d  in  26  jump target field of the D-stage instruction
rs_val_d  in  32  forwarded rs value for jr/jalr
instr_f  in  32  instruction word returned by instruction memory
im_addr  out  10  instruction-memory word address, bits [11:2] of (pc_f - IM_BASE)
pc_f  out  32  current F-stage PC
ir_d  out  32  IF/ID instruction register
pc_d  out  32  IF/ID PC of the instruction in ir_d
pc8_d  out  32  pc_d + 8, link value for jal/jalr
fetch_err_d  out  1  instruction in ir_d came from a faulting fetch

Behaviour:
- Reset (sync, highest priority): pc_f=PC_RESET, ir_d=0, pc_d=0, fetch_err_d=0. pc8_d follows pc_d, so it reads 8.
- im_addr is combinational from pc_f: (pc_f - IM_BASE)[11:2]. There is zero-cycle latency from pc_f to instr_f.
- Fault (combinational, F stage), fault_f=1 when either:
  - pc_f[1:0] != 0; or
  - pc_f < IM_BASE or pc_f >= IM_BASE + (4 << IM_WORDS_LOG2).
- Next-PC selection, when not stalled:
  - 00 → pc_f+4.
  - 01 → if br_taken, pc_d + 4 + (sign_ext(imm16_d) << 2); else pc_f+4.
  - 10 → {pc_d[31:28], index26_d, 2'b00}.
  - 11 → rs_val_d (unmodified; a misaligned value is fetched and faulted, not corrected).
- The delay slot is architectural: a redirect never squashes the instruction already in F, and it is latched into IF/ID normally.
- All address arithmetic is 32-bit modulo 2^32; wrap-around is not trapped except through the range check.
- Rising edge, not stalled:
  - pc_f <= next PC; pc_d <= pc_f.
  - If fault_f: ir_d <= 32'h0 (nop) and fetch_err_d <= 1.
  - Otherwise: ir_d <= instr_f and fetch_err_d <= 0.
- Rising edge, stalled:
  - pc_f, ir_d, pc_d and fetch_err_d all hold.
  - npc_sel and br_taken are ignored; decode re-presents them once the stall releases.
- stall and reset together: reset wins.
- stall during a faulting fetch: the fault is re-evaluated when the stall releases, since pc_f is unchanged.
- No internal FSM beyond the registers. Every register clears only on reset; there is no flush input (delay-slot ISA).

Test Plan:
- Reset high 2 cycles, then release and run with npc_sel=00 → cycle 0 after release: pc_f=0x3000, im_addr=0. After 3 edges: pc_f=0x300C, im_addr=3, pc_d=0x3008, ir_d=word 2 of code image.
- With pc_d=0x3004, npc_sel=01, br_taken=1, imm16_d=0xFFFF → next pc_f=0x3004, and the delay-slot instruction from 0x3008 lands in ir_d. Same stimulus with br_taken=0 → pc_f=0x300C.
- With pc_d=0x3010, npc_sel=10, index26_d=0x0000C40 → next pc_f=0x00003100. Same cycle: pc8_d=0x3018, usable as the jal link value.
- Hold stall=1 for 3 cycles while npc_sel=11, rs_val_d=0x3400 → pc_f, ir_d, pc_d unchanged. After release with npc_sel=00 → normal increment, and the jr is not applied.
- npc_sel=11, rs_val_d=0x3002 → next cycle fault_f. Following edge: ir_d=0, fetch_err_d=1, pc_d=0x3002. rs_val_d=0x4000 (out of range) → same result.
- Assert reset while stalled mid-stream at pc_f=0x3050 → the next edge gives pc_f=0x3000, ir_d=0, fetch_err_d=0, regardless of stall.
